// File: rtl/regbank_write_arbiter_pkg.sv
// Shared types and constants for the register-bank write arbiter.
// Contents: FSM state encoding, bus widths, register address map and
// the address-legality helper used by the WRITE state.
package regbank_write_arbiter_pkg;

  localparam int NUM_REGS = 5;
  localparam int ADDR_W   = 7;
  localparam int DATA_W   = 8;

  localparam logic [ADDR_W-1:0] REG1_ADDR = 7'd1;
  localparam logic [ADDR_W-1:0] REG2_ADDR = 7'd2;
  localparam logic [ADDR_W-1:0] REG3_ADDR = 7'd3;
  localparam logic [ADDR_W-1:0] REG4_ADDR = 7'd4;
  localparam logic [ADDR_W-1:0] REG5_ADDR = 7'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  // Legal targets are 1..NUM_REGS; address 0 and anything above are rejected.
  function automatic logic addr_legal(input logic [ADDR_W-1:0] addr);
    return (addr >= REG1_ADDR) && (addr <= ADDR_W'(NUM_REGS));
  endfunction

endpackage

// File: rtl/regbank_write_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin grant selector, purely combinational.
// Ports: req0/req1 requests in, last_grant = port served last (0/1),
//        gnt_vld = any request present, gnt = selected port index.
// Latency: zero; no backpressure of its own (the caller holds the grant).
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic gnt_vld,
  output logic gnt
);

  assign gnt_vld = req0 | req1;

  // On contention the port that was not served last wins, so neither
  // requester can be starved.
  always_comb begin
    gnt = 1'b0;
    if (req0 && req1) begin
      gnt = ~last_grant;
    end else if (req1) begin
      gnt = 1'b1;
    end
  end

endmodule

// File: rtl/regbank_write_arbiter.sv
// regbank_write_arbiter: two-master round-robin write port into the 5-entry
// 8-bit configuration register bank (reg1..reg5); sole driver of those regs.
// Latency: valid seen at edge N -> ready high in cycle N+1 -> write and
//          wr_done/wr_err at edge N+2; one write per 3 cycles.
// Backpressure: the loser's ready stays low and its request waits; masters
//          hold addr/data stable while valid && !ready.
// Ports: clk, rst (async, active-high); m0_*/m1_* valid/addr/data/ready
//        request ports; commit (shadow copy strobe); reg1..reg5 live values;
//        wr_done / wr_err one-cycle status pulses; busy = FSM not idle.
// Build option: REGBANK_SHADOW_EN -- writes land in shadow registers and a
//        commit pulse copies all shadows to reg1..reg5 on the next edge.
module regbank_write_arbiter
  import regbank_write_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_valid,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_data,
  output logic              m0_ready,
  input  logic              m1_valid,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_data,
  output logic              m1_ready,
  input  logic              commit,
  output logic [DATA_W-1:0] reg1,
  output logic [DATA_W-1:0] reg2,
  output logic [DATA_W-1:0] reg3,
  output logic [DATA_W-1:0] reg4,
  output logic [DATA_W-1:0] reg5,
  output logic              wr_done,
  output logic              wr_err,
  output logic              busy
);

  state_e              state_q, state_d;
  logic                grant_q, grant_d;
  logic                last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                m0_ready_q, m0_ready_d;
  logic                m1_ready_q, m1_ready_d;
  logic                wr_done_q, wr_done_d;
  logic                wr_err_q, wr_err_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   live_q [NUM_REGS];
  logic [DATA_W-1:0]   live_d [NUM_REGS];
`ifdef REGBANK_SHADOW_EN
  logic [DATA_W-1:0]   shadow_q [NUM_REGS];
  logic [DATA_W-1:0]   shadow_d [NUM_REGS];
`else
  logic                commit_unused;
  assign commit_unused = commit;
`endif

  logic arb_vld;
  logic arb_gnt;
  logic gnt_port_valid;

  rr_arb2 u_rr_arb2 (
    .req0       (m0_valid),
    .req1       (m1_valid),
    .last_grant (last_grant_q),
    .gnt_vld    (arb_vld),
    .gnt        (arb_gnt)
  );

  // Valid of whichever port currently holds the grant.
  assign gnt_port_valid = grant_q ? m1_valid : m0_valid;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    data_d       = data_q;
    m0_ready_d   = 1'b0;
    m1_ready_d   = 1'b0;
    wr_done_d    = 1'b0;
    wr_err_d     = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      live_d[i] = live_q[i];
`ifdef REGBANK_SHADOW_EN
      shadow_d[i] = shadow_q[i];
`endif
    end

    case (state_q)
      ST_IDLE: begin
        if (arb_vld) begin
          grant_d    = arb_gnt;
          m0_ready_d = ~arb_gnt;
          m1_ready_d = arb_gnt;
          state_d    = ST_XFER;
        end
      end
      ST_XFER: begin
        // A master that withdrew valid during its ready cycle transfers
        // nothing and does not consume its round-robin turn.
        if (gnt_port_valid) begin
          addr_d       = grant_q ? m1_addr : m0_addr;
          data_d       = grant_q ? m1_data : m0_data;
          last_grant_d = grant_q;
          state_d      = ST_WRITE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (addr_legal(addr_q)) begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_q == ADDR_W'(i + 1)) begin
`ifdef REGBANK_SHADOW_EN
              shadow_d[i] = data_q;
`else
              live_d[i] = data_q;
`endif
            end
          end
          wr_done_d = 1'b1;
        end else begin
          wr_err_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef REGBANK_SHADOW_EN
    // Copy from the post-write shadow so a coincident write is included.
    if (commit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        live_d[i] = shadow_d[i];
      end
    end
`endif

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      data_q       <= '0;
      m0_ready_q   <= 1'b0;
      m1_ready_q   <= 1'b0;
      wr_done_q    <= 1'b0;
      wr_err_q     <= 1'b0;
      busy_q       <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        live_q[i] <= '0;
`ifdef REGBANK_SHADOW_EN
        shadow_q[i] <= '0;
`endif
      end
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      m0_ready_q   <= m0_ready_d;
      m1_ready_q   <= m1_ready_d;
      wr_done_q    <= wr_done_d;
      wr_err_q     <= wr_err_d;
      busy_q       <= busy_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        live_q[i] <= live_d[i];
`ifdef REGBANK_SHADOW_EN
        shadow_q[i] <= shadow_d[i];
`endif
      end
    end
  end

  assign m0_ready = m0_ready_q;
  assign m1_ready = m1_ready_q;
  assign wr_done  = wr_done_q;
  assign wr_err   = wr_err_q;
  assign busy     = busy_q;
  assign reg1     = live_q[0];
  assign reg2     = live_q[1];
  assign reg3     = live_q[2];
  assign reg4     = live_q[3];
  assign reg5     = live_q[4];

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Bench for regbank_write_arbiter: directed scenarios followed by random
// two-master traffic, all outputs compared every cycle against a
// transaction-timeline reference model. Honours REGBANK_SHADOW_EN.
module tb_regbank_write_arbiter;

`ifdef REGBANK_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       m0_valid, m1_valid, commit;
  logic [6:0] m0_addr, m1_addr;
  logic [7:0] m0_data, m1_data;
  logic       m0_ready, m1_ready, wr_done, wr_err, busy;
  logic [7:0] reg1, reg2, reg3, reg4, reg5;

  regbank_write_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_data(m0_data), .m0_ready(m0_ready),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_data(m1_data), .m1_ready(m1_ready),
    .commit(commit),
    .reg1(reg1), .reg2(reg2), .reg3(reg3), .reg4(reg4), .reg5(reg5),
    .wr_done(wr_done), .wr_err(wr_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int err_seen, done_seen;
  bit auto_gen = 1'b0;

  // Reference model: a transaction is a timeline anchored at its grant edge
  // t0 -- ready during t0+1, capture at t0+1, write/status at t0+2.
  logic [7:0] m_regs [5];
  logic [7:0] m_shadow [5];
  bit         m_active, m_port, m_last;
  int         m_cyc, m_t0;
  logic [6:0] m_addr;
  logic [7:0] m_data;
  bit         e_rdy0, e_rdy1, e_done, e_err, e_busy;
  bit         served0, served1;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      m_regs[i] = 8'h00;
      m_shadow[i] = 8'h00;
    end
    m_active = 1'b0; m_last = 1'b1; m_port = 1'b0;
    e_rdy0 = 1'b0; e_rdy1 = 1'b0; e_done = 1'b0; e_err = 1'b0; e_busy = 1'b0;
    served0 = 1'b0; served1 = 1'b0;
  endtask

  task automatic model_edge();
    m_cyc++;
    e_rdy0 = 1'b0; e_rdy1 = 1'b0; e_done = 1'b0; e_err = 1'b0;
    served0 = 1'b0; served1 = 1'b0;
    if (!m_active) begin
      if (m0_valid || m1_valid) begin
        m_port   = (m0_valid && m1_valid) ? !m_last : m1_valid;
        m_active = 1'b1;
        m_t0     = m_cyc;
        if (m_port) e_rdy1 = 1'b1; else e_rdy0 = 1'b1;
      end
    end else if (m_cyc == m_t0 + 1) begin
      if (m_port ? m1_valid : m0_valid) begin
        m_addr = m_port ? m1_addr : m0_addr;
        m_data = m_port ? m1_data : m0_data;
        m_last = m_port;
        if (m_port) served1 = 1'b1; else served0 = 1'b1;
      end else begin
        m_active = 1'b0;
      end
    end else begin
      if (m_addr >= 1 && m_addr <= 5) begin
        if (SHADOW) m_shadow[m_addr - 1] = m_data;
        else        m_regs[m_addr - 1]   = m_data;
        e_done = 1'b1;
      end else begin
        e_err = 1'b1;
      end
      m_active = 1'b0;
    end
    if (SHADOW && commit) begin
      for (int i = 0; i < 5; i++) m_regs[i] = m_shadow[i];
    end
    e_busy = m_active;
  endtask

  task automatic check_all();
    chk("m0_ready", 40'(m0_ready), 40'(e_rdy0));
    chk("m1_ready", 40'(m1_ready), 40'(e_rdy1));
    chk("wr_done",  40'(wr_done),  40'(e_done));
    chk("wr_err",   40'(wr_err),   40'(e_err));
    chk("busy",     40'(busy),     40'(e_busy));
    chk("regs", {reg1, reg2, reg3, reg4, reg5},
        {m_regs[0], m_regs[1], m_regs[2], m_regs[3], m_regs[4]});
    if (wr_err === 1'b1) err_seen++;
    if (wr_done === 1'b1) done_seen++;
  endtask

  // One clock: model follows the edge, outputs checked on the falling edge,
  // then requesters react (served requests retire, random ones may start).
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
    if (served0) m0_valid = 1'b0;
    if (served1) m1_valid = 1'b0;
    commit = 1'b0;
    if (auto_gen) begin
      if (!m0_valid && $urandom_range(0, 2) == 0) begin
        m0_valid = 1'b1;
        m0_addr  = 7'($urandom_range(0, 7));
        m0_data  = 8'($urandom);
      end
      if (!m1_valid && $urandom_range(0, 2) == 0) begin
        m1_valid = 1'b1;
        m1_addr  = 7'($urandom_range(0, 7));
        m1_data  = 8'($urandom);
      end
      commit = ($urandom_range(0, 4) == 0);
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    m0_valid = 1'b0; m1_valid = 1'b0; commit = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    m0_valid = 1'b0; m0_addr = '0; m0_data = '0;
    m1_valid = 1'b0; m1_addr = '0; m1_data = '0;
    commit = 1'b0;
    m_cyc = 0; m_t0 = 0; m_addr = '0; m_data = '0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Single write from port 0.
    m0_valid = 1'b1; m0_addr = 7'd3; m0_data = 8'hA5;
    tick();
    chk("t1_ready_after_1", 40'(m0_ready), 40'(1));
    ticks(2);
    chk("t1_done_after_2", 40'(wr_done), 40'(1));
    chk("t1_reg3", 40'(reg3), 40'(SHADOW ? 8'h00 : 8'hA5));

    // Contention from reset: port 0 first, then port 1.
    tick();
    do_reset();
    m0_valid = 1'b1; m0_addr = 7'd1; m0_data = 8'h11;
    m1_valid = 1'b1; m1_addr = 7'd2; m1_data = 8'h22;
    done_seen = 0;
    ticks(6);
    chk("t2_done_count", 40'(done_seen), 40'(2));
    chk("t2_reg1", 40'(reg1), 40'(SHADOW ? 8'h00 : 8'h11));
    chk("t2_reg2", 40'(reg2), 40'(SHADOW ? 8'h00 : 8'h22));

    // Illegal addresses 0 and 6 from port 1.
    err_seen = 0; done_seen = 0;
    m1_valid = 1'b1; m1_addr = 7'd0; m1_data = 8'hEE;
    ticks(3);
    m1_valid = 1'b1; m1_addr = 7'd6; m1_data = 8'hDD;
    ticks(3);
    chk("t3_err_count", 40'(err_seen), 40'(2));
    chk("t3_done_count", 40'(done_seen), 40'(0));

    // Port 0 withdraws valid during its ready cycle; port 1 then completes.
    done_seen = 0;
    m0_valid = 1'b1; m0_addr = 7'd1; m0_data = 8'h77;
    tick();
    m0_valid = 1'b0;
    tick();
    chk("t4_busy_after_abort", 40'(busy), 40'(0));
    m1_valid = 1'b1; m1_addr = 7'd2; m1_data = 8'h99;
    ticks(3);
    chk("t4_done_count", 40'(done_seen), 40'(1));
    chk("t4_reg1_untouched", 40'(reg1), 40'(SHADOW ? 8'h00 : 8'h11));
    chk("t4_reg2", 40'(reg2), 40'(SHADOW ? 8'h00 : 8'h99));

    // Reset asserted while the write of reg5 is in flight.
    m0_valid = 1'b1; m0_addr = 7'd5; m0_data = 8'hFF;
    ticks(2);
    chk("t5_busy_in_write", 40'(busy), 40'(1));
    do_reset();
    chk("t5_reg5_at_reset", 40'(reg5), 40'(0));
    chk("t5_busy_at_reset", 40'(busy), 40'(0));
    ticks(4);
    chk("t5_reg5_after", 40'(reg5), 40'(0));

    // Shadow staging and commit (plain live writes when shadows are absent).
    m0_valid = 1'b1; m0_addr = 7'd4; m0_data = 8'h3C;
    ticks(3);
    chk("t6_reg4_before_commit", 40'(reg4), 40'(SHADOW ? 8'h00 : 8'h3C));
    commit = 1'b1;
    tick();
    chk("t6_reg4_after_commit", 40'(reg4), 40'(8'h3C));
    m0_valid = 1'b1; m0_addr = 7'd4; m0_data = 8'h55;
    ticks(2);
    commit = 1'b1;
    tick();
    chk("t6_reg4_coincident", 40'(reg4), 40'(8'h55));

    // Random two-master traffic with random commit strobes.
    auto_gen = 1'b1;
    ticks(500);
    auto_gen = 1'b0;
    commit = 1'b0;
    ticks(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
